// File: rtl/inst_bus_if.sv
// Instruction-side bridge: turns a single-cycle core fetch into a Wishbone B3 classic read,
// stalls the pipeline while the read is outstanding, and holds the fetched word under a stall.
module inst_bus_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StWaitStall} state_e;

  state_e            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic              cyc_q, cyc_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic [CntW-1:0]   tcnt_q, tcnt_d;
  logic              timeout_hit;

  // Only the IF-stage hold bit matters to this bridge.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  assign timeout_hit = (TIMEOUT != 0) && (32'(tcnt_q) == TIMEOUT - 1);

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    rd_buf_d   = rd_buf_q;
    tcnt_d     = tcnt_q;
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    bus_err_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_ce_i && !flush_i) begin
          adr_d      = cpu_addr_i;
          cyc_d      = 1'b1;
          tcnt_d     = '0;
          state_d    = StBusy;
          stallreq_o = 1'b1;
        end
      end
      StBusy: begin
        if (flush_i) begin
          cyc_d   = 1'b0;
          state_d = StIdle;
        end else if (wb_ack_i) begin
          cyc_d      = 1'b0;
          cpu_data_o = wb_dat_i;
          if (stall_i[1]) begin
            rd_buf_d = wb_dat_i;
            state_d  = StWaitStall;
          end else begin
            state_d = StIdle;
          end
        end else if (timeout_hit) begin
          cyc_d     = 1'b0;
          state_d   = StIdle;
          bus_err_o = 1'b1;
        end else begin
          tcnt_d     = tcnt_q + 1'b1;
          stallreq_o = 1'b1;
        end
      end
      StWaitStall: begin
        cpu_data_o = rd_buf_q;
        if (!stall_i[1] || flush_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      adr_q    <= 32'h0;
      cyc_q    <= 1'b0;
      rd_buf_q <= 32'h0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'b1111;

endmodule

// File: tb/tb_inst_bus_if.sv
// Self-checking bench for inst_bus_if: directed scenarios then randomized fetches, each cycle's
// expected outputs derived from fetch-level rules (issue, wait states, ack, hold, flush, timeout).
module tb_inst_bus_if;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] last_adr = 32'h0;

  inst_bus_if #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_o (cpu_data_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] stall_vec(input logic b1);
    logic [5:0] v;
    v    = 6'($urandom);
    v[1] = b1;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge, then check the outputs.
  task automatic step(input logic ce, input logic [31:0] addr, input logic ack,
                      input logic [31:0] dat, input logic [5:0] stl, input logic fl,
                      input logic rs, input logic e_sr, input logic [31:0] e_d,
                      input logic e_err, input logic e_cyc, input string tag);
    @(negedge clk);
    cpu_ce_i   = ce;
    cpu_addr_i = addr;
    wb_ack_i   = ack;
    wb_dat_i   = dat;
    stall_i    = stl;
    flush_i    = fl;
    rst        = rs;
    #1;
    n_cmp++;
    assert (stallreq_o === e_sr) else begin
      n_bad++; $error("FAIL %s stallreq got %b want %b", tag, stallreq_o, e_sr);
    end
    n_cmp++;
    assert (cpu_data_o === e_d) else begin
      n_bad++; $error("FAIL %s cpu_data got %h want %h", tag, cpu_data_o, e_d);
    end
    n_cmp++;
    assert (bus_err_o === e_err) else begin
      n_bad++; $error("FAIL %s bus_err got %b want %b", tag, bus_err_o, e_err);
    end
    n_cmp++;
    assert ({wb_cyc_o, wb_stb_o} === {e_cyc, e_cyc}) else begin
      n_bad++; $error("FAIL %s cyc/stb got %b%b want %b", tag, wb_cyc_o, wb_stb_o, e_cyc);
    end
    n_cmp++;
    assert (wb_adr_o === last_adr) else begin
      n_bad++; $error("FAIL %s wb_adr got %h want %h", tag, wb_adr_o, last_adr);
    end
    n_cmp++;
    assert ({wb_we_o, wb_sel_o} === 5'b01111) else begin
      n_bad++; $error("FAIL %s we/sel got %b%h want 0f", tag, wb_we_o, wb_sel_o);
    end
  endtask

  // Bus idle: no fetch request (or a flushed one); a stray ack must be ignored.
  task automatic idle_cycle(input logic ce_flushed);
    step(ce_flushed, $urandom, 1'($urandom), $urandom, stall_vec(1'($urandom)), ce_flushed,
         1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
  endtask

  // One fetch. waits = BUSY cycles before ack; flush_at = BUSY index of a flush (-1 none).
  // With hold_on_ack the word is held for hold extra stalled cycles plus one release cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits,
                       input int flush_at, input logic hold_on_ack, input int hold);
    step(1'b1, addr, 1'($urandom), $urandom, stall_vec(1'($urandom)), 1'b0, 1'b0,
         1'b1, 32'h0, 1'b0, 1'b0, "issue");
    last_adr = addr;
    for (int k = 0; k < 64; k++) begin
      if (k == flush_at) begin
        step(1'($urandom), $urandom, (k == waits), data, stall_vec(1'($urandom)), 1'b1, 1'b0,
             1'b0, 32'h0, 1'b0, 1'b1, "flush");
        return;
      end else if (k == waits) begin
        step(1'($urandom), $urandom, 1'b1, data, stall_vec(hold_on_ack), 1'b0, 1'b0,
             1'b0, data, 1'b0, 1'b1, "ack");
        break;
      end else if (k == int'(TO) - 1) begin
        step(1'($urandom), $urandom, 1'b0, $urandom, stall_vec(1'($urandom)), 1'b0, 1'b0,
             1'b0, 32'h0, 1'b1, 1'b1, "timeout");
        return;
      end else begin
        step(1'($urandom), $urandom, 1'b0, $urandom, stall_vec(1'($urandom)), 1'b0, 1'b0,
             1'b1, 32'h0, 1'b0, 1'b1, "wait");
      end
    end
    if (hold_on_ack) begin
      for (int j = 0; j < hold; j++) begin
        step(1'($urandom), $urandom, 1'($urandom), $urandom, stall_vec(1'b1), 1'b0, 1'b0,
             1'b0, data, 1'b0, 1'b0, "hold");
      end
      begin
        logic fl;
        fl = 1'($urandom);
        step(1'($urandom), $urandom, 1'($urandom), $urandom, stall_vec(fl), fl, 1'b0,
             1'b0, data, 1'b0, 1'b0, "release");
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    cpu_ce_i   = 1'b0;
    cpu_addr_i = 32'h0;
    wb_ack_i   = 1'b0;
    wb_dat_i   = 32'h0;
    stall_i    = 6'h0;
    flush_i    = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, with ack noise that must not matter.
    step(1'b0, 32'h0, 1'b1, 32'h1234_5678, 6'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "rst");
    step(1'b0, 32'h0, 1'b1, 32'h1234_5678, 6'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
         "post_rst");

    // Zero-wait fetches back to back.
    fetch(32'h0000_0000, 32'h3401_1100, 0, -1, 1'b0, 0);
    fetch(32'h0000_0004, 32'h3402_0020, 0, -1, 1'b0, 0);
    // Three wait states.
    fetch(32'h0000_0008, 32'hCAFE_0001, 3, -1, 1'b0, 0);
    // Ack under IF stall: word held for 3 cycles in total.
    fetch(32'h0000_000C, 32'hA5A5_5A5A, 0, -1, 1'b1, 2);
    fetch(32'h0000_0010, 32'h0BAD_F00D, 1, -1, 1'b0, 0);
    // Slave never acks.
    fetch(32'h0000_0014, 32'hFFFF_FFFF, 100, -1, 1'b0, 0);
    fetch(32'h0000_0018, 32'h1111_2222, 0, -1, 1'b0, 0);
    // Flush coinciding with ack.
    fetch(32'h0000_001C, 32'hDEAD_BEEF, 1, 1, 1'b0, 0);
    idle_cycle(1'b1);
    fetch(32'h0000_0020, 32'h3333_4444, 0, -1, 1'b0, 0);

    // Reset during the second BUSY cycle, then a late ack.
    step(1'b1, 32'h0000_0024, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0,
         "r_issue");
    last_adr = 32'h0000_0024;
    step(1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, "r_busy1");
    step(1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, "r_busy2");
    last_adr = 32'h0;
    step(1'b0, 32'h0, 1'b1, 32'h7777_8888, 6'h2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
         "r_late_ack");
    step(1'b0, 32'h0, 1'b1, 32'h7777_8888, 6'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
         "r_after");
    fetch(32'h0000_0028, 32'h5555_6666, 2, -1, 1'b1, 1);

    // Randomized fetches.
    for (int i = 0; i < 200; i++) begin
      int w;
      int fa;
      w  = int'($urandom_range(0, 6));
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
      fetch({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, w, fa, 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_bus_if.md
# inst_bus_if

Instruction-side bus bridge between the CPU core's instruction port (`rom_ce_o`, `rom_addr_o`, `rom_data_i`) and a Wishbone B3 classic master port. The bridge converts the core's single-cycle fetch request into a handshaked bus read. While a transfer is outstanding it raises a stall request to the pipeline controller. It returns the fetched word to IF/ID, and holds that word if the pipeline is stalled by another stage.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum BUSY cycles before a transfer is aborted; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_ce_i`  in  1  fetch request from the PC stage (driven by `rom_ce_o`).
- `cpu_addr_i`  in  32  fetch byte address (driven by `rom_addr_o`).
- `cpu_data_o`  out  32  instruction word to IF/ID (drives `rom_data_i`).
- `stall_i`  in  6  controller stall vector; bit 1 = IF stage held.
- `flush_i`  in  1  abandon the current fetch; tied 0 until exceptions land.
- `stallreq_o`  out  1  stall request to the controller.
- `bus_err_o`  out  1  one-cycle pulse when a transfer times out.
- `wb_adr_o`  out  32  bus address.
- `wb_dat_i`  in  32  bus read data.
- `wb_ack_i`  in  1  bus acknowledge.
- `wb_cyc_o`  out  1  bus cycle.
- `wb_stb_o`  out  1  bus strobe.
- `wb_we_o`  out  1  constant 0.
- `wb_sel_o`  out  4  constant 4'b1111.

## Operation
- The FSM has three states: IDLE, BUSY and WAIT_STALL. Registers are the state, `wb_adr_o`, `wb_cyc_o`, `wb_stb_o`, a 32-bit `rd_buf` and a timeout counter `tcnt`.
- IDLE:
  - If `cpu_ce_i`=1 and `flush_i`=0: register `wb_adr_o`<=`cpu_addr_i`, set `wb_cyc_o`=`wb_stb_o`<=1, clear `tcnt`, go to BUSY. Outputs this cycle: `stallreq_o`=1, `cpu_data_o`=0.
  - Otherwise: `stallreq_o`=0 and `cpu_data_o`=0.
- BUSY, priority order:
  1. `flush_i`=1: drop `wb_cyc_o`/`wb_stb_o` and go to IDLE. Any coincident ack is discarded. `stallreq_o`=0, `cpu_data_o`=0.
  2. `wb_ack_i`=1: drop `wb_cyc_o`/`wb_stb_o`. `cpu_data_o`=`wb_dat_i` and `stallreq_o`=0 (combinational). If `stall_i[1]`=1, capture `rd_buf`<=`wb_dat_i` and go to WAIT_STALL; otherwise go to IDLE.
  3. `TIMEOUT`!=0 and `tcnt`==`TIMEOUT`-1: drop `wb_cyc_o`/`wb_stb_o` and go to IDLE. `bus_err_o`=1, `cpu_data_o`=0 (a NOP), `stallreq_o`=0.
  4. Otherwise: increment `tcnt` and stay in BUSY. `stallreq_o`=1, `cpu_data_o`=0.
- WAIT_STALL: `cpu_data_o`=`rd_buf` and `stallreq_o`=0. Go to IDLE when `stall_i[1]`=0 or `flush_i`=1.
- `stallreq_o`, `cpu_data_o` and `bus_err_o` depend only on state, `cpu_ce_i`, `flush_i`, `wb_ack_i`, `wb_dat_i` and `tcnt`. They never depend on `stall_i`, which prevents a combinational loop through the controller. `stall_i` affects next state only.
- `wb_adr_o`, `wb_dat_i` and `cpu_addr_i` are passed through unmodified. Word alignment is the PC's responsibility.

## Timing
- Reset values: state IDLE; `wb_cyc_o`=`wb_stb_o`=0; `wb_adr_o`=0; `rd_buf`=0; `tcnt`=0; `stallreq_o`=0; `bus_err_o`=0; `cpu_data_o`=0.
- Reset applied mid-transfer forces IDLE on that edge and drops `wb_cyc_o`/`wb_stb_o`. A later ack is ignored.
- Minimum fetch is 2 cycles: an IDLE issue cycle, then a BUSY cycle with ack. A slave with N wait states costs 2+N cycles.
- The PC holds throughout because `stallreq_o`=1 in the issue cycle and in every BUSY cycle without ack.
- `wb_cyc_o`/`wb_stb_o` rise on the edge leaving IDLE and fall on the edge that samples ack, flush or timeout. `wb_adr_o` is stable throughout BUSY.
- Ack is sampled only in BUSY; an ack seen in IDLE or WAIT_STALL is ignored.
- `bus_err_o` is high for exactly one cycle per timeout.
- Back-to-back fetches leave one IDLE cycle between bus cycles (`wb_cyc_o` low for at least 1 cycle).

## Test plan
- Zero-wait slave, `cpu_ce_i`=1, addr 0x00000000 then 0x00000004, data 0x34011100/0x34020020 -> each word appears on `cpu_data_o` in its ack cycle; `stallreq_o` pattern 1,0,1,0; `wb_adr_o` 0x0 then 0x4.
- Slave with 3 wait states -> `stallreq_o` high for 4 cycles, data delivered in the 5th cycle, `wb_cyc_o` high for exactly 4 cycles.
- Ack coincident with `stall_i`=6'b000011 held for 3 cycles -> WAIT_STALL; `cpu_data_o`=`rd_buf` for 3 cycles with `stallreq_o`=0, then IDLE and a new issue.
- `TIMEOUT`=4, slave never acks -> `bus_err_o` pulses in the 4th BUSY cycle, `cpu_data_o`=0, `wb_cyc_o` drops, next fetch issues normally.
- `flush_i`=1 in the same cycle as ack with data 0xDEADBEEF -> data discarded, `cpu_data_o`=0, state IDLE.
- `rst`=1 during the 2nd BUSY cycle -> next cycle all outputs at reset values; a late ack produces no data and no state change.
